// File: rtl/uart_tx_framed.sv
// uart_tx_framed: UART transmitter with a small TX FIFO in front of it.
// Frames are start, DATA_BITS data bits sent LSB first, an optional parity
// bit, then STOP_BITS stop bits. Queued words go out back-to-back.
// Optional feature: define UART_TX_BREAK_EN to add the brk input, which
// holds the line low (break condition) whenever the transmitter is between
// frames.
module uart_tx_framed #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef UART_TX_BREAK_EN
  input  logic                          brk,
`endif
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          dout
);

  localparam int CLOCKS_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  // Reject illegal configurations at elaboration time
  if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_framed: CLOCKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_framed: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_framed: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK, S_GAP
`endif
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_clk_cnt, w_clk_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
  logic                 r_dout, w_dout_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 w_push, w_pop, w_clk_last, w_fifo_empty;
  logic [DATA_BITS-1:0] w_head;

  // Line value of the parity bit from the XOR of all data bits
  function automatic logic parity_bit(input logic acc);
    return (PARITY == 1) ? ~acc : acc;
  endfunction

  assign din_ready    = (r_count != FULL_CNT);
  assign w_push       = din_valid && din_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_clk_last   = (r_clk_cnt == CLK_LAST);
  assign fifo_count   = r_count;
  assign dout         = r_dout;
  assign busy         = !w_fifo_empty || (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);

  // Control state: FSM, counters, line register and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_dout    <= 1'b1;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_dout    <= w_dout_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Datapath: FIFO storage and frame shift register need no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
    if (w_pop) begin
      r_shift <= w_head;
      r_par   <= 1'b0;
    end else if (r_state == S_DATA && w_clk_last) begin
      r_shift <= r_shift >> 1;
      r_par   <= r_par ^ r_shift[0];
    end
  end

  // Next state, counters and registered line value; pops happen here
  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_dout_nxt  = r_dout;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_dout_nxt = 1'b1;
        w_clk_nxt  = '0;
        w_bit_nxt  = '0;
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          w_state_nxt = S_BREAK;
          w_dout_nxt  = 1'b0;
        end else
`endif
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_dout_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (w_clk_last) begin
          w_clk_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
          w_dout_nxt  = r_shift[0];
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_clk_last) begin
          w_clk_nxt = '0;
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_nxt = '0;
            if (PARITY != 0) begin
              w_state_nxt = S_PARITY;
              w_dout_nxt  = parity_bit(r_par ^ r_shift[0]);
            end else begin
              w_state_nxt = S_STOP;
              w_dout_nxt  = 1'b1;
            end
          end else begin
            w_bit_nxt  = r_bit_cnt + 1'b1;
            w_dout_nxt = r_shift[1];
          end
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_clk_last) begin
          w_clk_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_STOP;
          w_dout_nxt  = 1'b1;
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_clk_last) begin
          w_clk_nxt = '0;
          if (r_bit_cnt == STOP_LAST) begin
            w_bit_nxt = '0;
`ifdef UART_TX_BREAK_EN
            if (brk) begin
              w_state_nxt = S_BREAK;
              w_dout_nxt  = 1'b0;
            end else
`endif
            if (!w_fifo_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = S_START;
              w_dout_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_dout_nxt  = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        w_dout_nxt = 1'b0;
        w_clk_nxt  = '0;
        if (!brk) begin
          w_state_nxt = S_GAP;
          w_dout_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        // One full idle bit time after a break before the next start bit
        if (brk) begin
          w_state_nxt = S_BREAK;
          w_dout_nxt  = 1'b0;
          w_clk_nxt   = '0;
        end else if (w_clk_last) begin
          w_clk_nxt = '0;
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_dout_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_dout_nxt  = 1'b1;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_dout_nxt  = 1'b1;
      end
    endcase
  end

endmodule
